distance_filter: RTL and testbench
==================================

DISTANCE_FILTER -- requirements
Module: distance_filter

Interface
REQ-001 The block SHALL have parameter MAX_CM, default 200, the largest accepted distance in cm.
REQ-002 The block SHALL have parameter ALARM_CM, default 30, the alarm-assert threshold in cm.
REQ-003 The block SHALL have parameter HYST_CM, default 5, the alarm-release hysteresis in cm.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, the no-sample cycles before data is declared stale.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock, 50 MHz; all logic is on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port sample_valid, input, 1 bit: a one-cycle strobe from the ultrasonic ranger that marks a new measurement.
REQ-008 The block SHALL have port sample_cm, input, 8 bits: the raw distance in cm, sampled only while sample_valid=1.
REQ-009 The block SHALL have port filtered_cm, output, 8 bits: the 4-sample moving average in cm, to BCD/display and the tone generator.
REQ-010 The block SHALL have port filtered_strobe, output, 1 bit: a one-cycle pulse for each new filtered_cm value.
REQ-011 The block SHALL have port filtered_valid, output, 1 bit: a level that is high while the window is full and the data is not stale.
REQ-012 The block SHALL have port alarm, output, 1 bit: proximity alarm with hysteresis.
REQ-013 The block SHALL have port stale, output, 1 bit: high when no sample has arrived within TIMEOUT_CYCLES.
REQ-014 The block SHALL have port reject_count, output, 8 bits: a saturating count of rejected samples.

Function
REQ-015 A sample SHALL be accepted when sample_valid=1 and 1 <= sample_cm <= MAX_CM; any other sample SHALL be rejected.
REQ-016 A rejected sample SHALL leave the window, the sum and filtered_cm unchanged, and SHALL increment reject_count, which saturates at 255.
REQ-017 The window SHALL be a 4-entry ring buffer with a 2-bit write pointer that wraps 3->0, a 3-bit fill count that saturates at 4, and a 10-bit running sum.
REQ-018 On an accepted sample, the block SHALL update in one edge: sum <= sum - buf[wp] + sample_cm; buf[wp] <= sample_cm; wp <= wp+1; fill <= min(fill+1,4).
REQ-019 Slots that have not been filled SHALL read as 0, so the subtraction is exact while the window fills.
REQ-020 When the accepted sample makes fill equal to 4, or fill is already 4, the block SHALL set filtered_cm to the new sum with its two LSBs truncated, and SHALL pulse filtered_strobe, on the same edge that captures sample_valid.
REQ-021 The latency from sample_valid to filtered_strobe SHALL be 1 cycle.
REQ-022 While fill < 4, filtered_strobe SHALL stay 0 and filtered_cm SHALL hold its previous value.
REQ-023 filtered_valid SHALL be 1 exactly when fill=4 and stale=0.
REQ-024 The alarm SHALL be evaluated only on the filtered_strobe edge, using the new average A.
REQ-025 On that edge, the alarm SHALL be set when A < ALARM_CM, cleared when A >= ALARM_CM+HYST_CM, and held otherwise.
REQ-026 A 27-bit timeout counter SHALL clear to 0 on every sample_valid, whether the sample is accepted or rejected, and SHALL increment otherwise, saturating at TIMEOUT_CYCLES.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES-1 with no sample_valid on that edge, the block SHALL set stale=1, clear fill, sum, wp, all buffer entries and alarm, and hold filtered_cm.
REQ-028 A sample_valid on the same edge as the expiry SHALL win: no flush, stale stays 0, and the sample is processed normally.
REQ-029 The first accepted sample after a stale period SHALL clear stale; filtered_valid returns only after 4 accepted samples.
REQ-030 A rejected sample SHALL clear the timeout counter and SHALL NOT clear stale.
REQ-031 All arithmetic SHALL be unsigned, and the sum SHALL never exceed 4*MAX_CM, which is at most 1020 and so fits 10 bits.

Reset
REQ-032 While resetn=0, the block SHALL asynchronously force: filtered_cm=0, filtered_strobe=0, filtered_valid=0, alarm=0, stale=0, reject_count=0, fill=0, wp=0, sum=0, all buffer entries=0, timeout counter=0.
REQ-033 Reset asserted mid-window SHALL discard all partial state, with no output pulse on reset release.
REQ-034 The first edge after resetn deasserts SHALL behave as a normal cycle.

Verification
REQ-035 Fill and latency: accepted samples 100, 104, 108, 112 -> no strobe for the first three; on the fourth, filtered_cm=106, filtered_strobe pulses for 1 cycle at the capturing edge, filtered_valid=1.
REQ-036 Wrap-around: after 100, 104, 108, 112, send 200 -> filtered_cm=(104+108+112+200)>>2=131, wp wraps to 1.
REQ-037 Rejection: with the window full of 50s, send 0, then 201, then 255 -> filtered_cm stays 50, no strobe, reject_count=3.
REQ-038 Rejection saturation: 300 rejected samples -> reject_count=255.
REQ-039 Hysteresis: window at 40, then feed so the average goes 29 -> 33 -> 35 -> alarm=1, then 1, then 0.
REQ-040 Timeout: TIMEOUT_CYCLES=1000, window full, no samples -> at cycle 999 after the last strobe, stale=1, filtered_valid=0, alarm=0.
REQ-041 Timeout collision: with TIMEOUT_CYCLES=1000, a sample exactly at cycle 999 -> no flush, stale stays 0.
REQ-042 Reset mid-operation: assert resetn=0 asynchronously between clock edges after 2 accepted samples -> all outputs are 0 immediately; after release, 4 new samples of 60 give filtered_cm=60.

Source files
------------

// File: rtl/distance_filter.sv
// Ultrasonic range filter: 4-sample moving average with range rejection,
// hysteretic proximity alarm and a no-sample staleness timeout.
module distance_filter #(
  parameter int MAX_CM         = 200,
  parameter int ALARM_CM       = 30,
  parameter int HYST_CM        = 5,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  // sample_valid is a one-cycle strobe with no back-pressure: every cycle it is
  // high, sample_cm is consumed (accepted or rejected) on that rising edge.
  input  logic       sample_valid,
  input  logic [7:0] sample_cm,
  output logic [7:0] filtered_cm,
  output logic       filtered_strobe,
  output logic       filtered_valid,
  output logic       alarm,
  output logic       stale,
  output logic [7:0] reject_count
);

  localparam logic [8:0]  MAX_V    = 9'(MAX_CM);
  localparam logic [9:0]  ALARM_V  = 10'(ALARM_CM);
  localparam logic [9:0]  REL_V    = 10'(ALARM_CM + HYST_CM);
  localparam logic [26:0] TMO_V    = 27'(TIMEOUT_CYCLES);
  localparam logic [26:0] EXPIRE_V = 27'(TIMEOUT_CYCLES - 2);

  logic [7:0]  win [4];
  logic [1:0]  wp;
  logic [2:0]  fill;
  logic [9:0]  sum;
  logic [26:0] tcnt;

  logic       accept;
  logic       reject;
  logic       expire;
  logic [9:0] sum_next;
  logic [2:0] fill_next;
  logic [7:0] avg_next;

  always_comb begin
    accept    = sample_valid && (sample_cm != 8'd0) && ({1'b0, sample_cm} <= MAX_V);
    reject    = sample_valid && !accept;
    // Counter is about to reach TIMEOUT_CYCLES-1; a sample on this edge wins.
    expire    = !sample_valid && (tcnt == EXPIRE_V);
    // Unfilled slots hold 0, so this subtraction is exact during fill-up.
    sum_next  = sum - {2'b00, win[wp]} + {2'b00, sample_cm};
    fill_next = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    avg_next  = sum_next[9:2];
  end

  assign filtered_valid = (fill == 3'd4) && !stale;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) win[i] <= 8'd0;
      wp              <= 2'd0;
      fill            <= 3'd0;
      sum             <= 10'd0;
      tcnt            <= 27'd0;
      filtered_cm     <= 8'd0;
      filtered_strobe <= 1'b0;
      alarm           <= 1'b0;
      stale           <= 1'b0;
      reject_count    <= 8'd0;
    end else begin
      filtered_strobe <= 1'b0;

      if (sample_valid) tcnt <= 27'd0;
      else if (tcnt != TMO_V) tcnt <= tcnt + 27'd1;

      if (reject && (reject_count != 8'hff)) reject_count <= reject_count + 8'd1;

      if (expire) begin
        for (int i = 0; i < 4; i++) win[i] <= 8'd0;
        wp    <= 2'd0;
        fill  <= 3'd0;
        sum   <= 10'd0;
        alarm <= 1'b0;
        stale <= 1'b1;
      end else if (accept) begin
        win[wp] <= sample_cm;
        sum     <= sum_next;
        wp      <= wp + 2'd1;
        fill    <= fill_next;
        stale   <= 1'b0;
        if (fill_next == 3'd4) begin
          filtered_cm     <= avg_next;
          filtered_strobe <= 1'b1;
          if ({2'b00, avg_next} < ALARM_V) alarm <= 1'b1;
          else if ({2'b00, avg_next} >= REL_V) alarm <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_distance_filter.sv
// Bench for distance_filter: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model of the filter.
module tb_distance_filter;

  localparam int MAX_CM = 200;
  localparam int ALARM_CM = 30;
  localparam int HYST_CM = 5;
  localparam int TMO = 1000;

  logic       clock;
  logic       resetn;
  logic       sample_valid;
  logic [7:0] sample_cm;
  logic [7:0] filtered_cm;
  logic       filtered_strobe;
  logic       filtered_valid;
  logic       alarm;
  logic       stale;
  logic [7:0] reject_count;

  int total = 0;
  int bad = 0;

  distance_filter #(
    .MAX_CM(MAX_CM), .ALARM_CM(ALARM_CM), .HYST_CM(HYST_CM), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .resetn(resetn), .sample_valid(sample_valid), .sample_cm(sample_cm),
    .filtered_cm(filtered_cm), .filtered_strobe(filtered_strobe),
    .filtered_valid(filtered_valid), .alarm(alarm), .stale(stale),
    .reject_count(reject_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #10 clock = ~clock;

  // behavioural model: last accepted samples in a queue
  int m_win[$];
  int m_cm, m_strobe, m_alarm, m_stale, m_rej, m_tcnt;

  function automatic int m_valid();
    return (m_win.size() == 4 && m_stale == 0) ? 1 : 0;
  endfunction

  task automatic m_reset();
    m_win.delete();
    m_cm = 0; m_strobe = 0; m_alarm = 0; m_stale = 0; m_rej = 0; m_tcnt = 0;
  endtask

  task automatic m_step(input int v, input int cm);
    int s;
    bit acc;
    acc = (v != 0) && (cm >= 1) && (cm <= MAX_CM);
    m_strobe = 0;
    if (v != 0) m_tcnt = 0;
    else if (m_tcnt < TMO) begin
      m_tcnt++;
      if (m_tcnt == TMO - 1) begin
        m_stale = 1;
        m_win.delete();
        m_alarm = 0;
      end
    end
    if (acc) begin
      m_win.push_back(cm);
      if (m_win.size() > 4) void'(m_win.pop_front());
      m_stale = 0;
      if (m_win.size() == 4) begin
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        m_cm = s / 4;
        m_strobe = 1;
        if (m_cm < ALARM_CM) m_alarm = 1;
        else if (m_cm >= ALARM_CM + HYST_CM) m_alarm = 0;
      end
    end else if (v != 0) begin
      m_rej = (m_rej < 255) ? m_rej + 1 : 255;
    end
  endtask

  // driver tasks
  task automatic apply_reset();
    resetn = 1'b0;
    sample_valid = 1'b0;
    sample_cm = 8'd0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    m_reset();
  endtask

  task automatic drive(input int v, input int cm);
    sample_valid = (v != 0);
    sample_cm = 8'(cm);
    @(posedge clock);
    m_step(v, cm);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({filtered_cm, filtered_strobe, filtered_valid, alarm, stale, reject_count} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {filtered_cm, filtered_strobe, filtered_valid, alarm, stale, reject_count});
    end
  endtask

  task automatic test_fill();
    int vals[4] = '{100, 104, 108, 112};
    int exp_strobe[4] = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      drive(1, vals[i]);
      total++;
      if (filtered_strobe !== exp_strobe[i][0]) begin
        bad++;
        $display("FAIL fill_strobe[%0d]: got %0d want %0d", i, filtered_strobe, exp_strobe[i]);
      end
    end
    total++;
    if (filtered_cm !== 8'd106 || filtered_valid !== 1'b1) begin
      bad++;
      $display("FAIL fill_avg: got cm=%0d valid=%0d want cm=106 valid=1", filtered_cm, filtered_valid);
    end
    drive(0, 0);
    total++;
    if (filtered_strobe !== 1'b0) begin
      bad++;
      $display("FAIL fill_pulse_width: got strobe=%0d want 0", filtered_strobe);
    end
  endtask

  task automatic test_wrap();
    drive(1, 200);
    total++;
    if (filtered_cm !== 8'd131 || filtered_strobe !== 1'b1) begin
      bad++;
      $display("FAIL wrap_avg: got cm=%0d strobe=%0d want cm=131 strobe=1", filtered_cm, filtered_strobe);
    end
    drive(1, 4);
    total++;
    if (filtered_cm !== 8'd106 || filtered_cm !== 8'(m_cm)) begin
      bad++;
      $display("FAIL wrap_second: got cm=%0d want 106", filtered_cm);
    end
  endtask

  task automatic test_reject();
    int bad_vals[3] = '{0, 201, 255};
    apply_reset();
    repeat (4) drive(1, 50);
    for (int i = 0; i < 3; i++) begin
      drive(1, bad_vals[i]);
      total++;
      if (filtered_strobe !== 1'b0 || filtered_cm !== 8'd50) begin
        bad++;
        $display("FAIL reject_hold[%0d]: got cm=%0d strobe=%0d want cm=50 strobe=0",
                 i, filtered_cm, filtered_strobe);
      end
    end
    total++;
    if (reject_count !== 8'd3) begin
      bad++;
      $display("FAIL reject_count: got %0d want 3", reject_count);
    end
    drive(1, 200);
    total++;
    if (filtered_cm !== 8'd87) begin
      bad++;
      $display("FAIL reject_window_intact: got %0d want 87", filtered_cm);
    end
  endtask

  task automatic test_reject_saturation();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) drive(1, 0);
      else drive(1, $urandom_range(201, 255));
    end
    total++;
    if (reject_count !== 8'd255) begin
      bad++;
      $display("FAIL reject_saturate: got %0d want 255", reject_count);
    end
  endtask

  task automatic test_hysteresis();
    int feed[4] = '{1, 38, 53, 48};
    int exp_cm[4] = '{30, 29, 33, 35};
    int exp_alarm[4] = '{0, 1, 1, 0};
    apply_reset();
    repeat (4) drive(1, 40);
    for (int i = 0; i < 4; i++) begin
      drive(1, feed[i]);
      total++;
      if (filtered_cm !== 8'(exp_cm[i]) || alarm !== exp_alarm[i][0]) begin
        bad++;
        $display("FAIL hyst[%0d]: got cm=%0d alarm=%0d want cm=%0d alarm=%0d",
                 i, filtered_cm, alarm, exp_cm[i], exp_alarm[i]);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    repeat (4) drive(1, 20);
    repeat (TMO - 2) drive(0, 0);
    total++;
    if (stale !== 1'b0 || alarm !== 1'b1 || filtered_valid !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: got stale=%0d alarm=%0d valid=%0d want 0 1 1",
               stale, alarm, filtered_valid);
    end
    drive(0, 0);
    total++;
    if (stale !== 1'b1 || alarm !== 1'b0 || filtered_valid !== 1'b0 || filtered_cm !== 8'd20) begin
      bad++;
      $display("FAIL timeout_expire: got stale=%0d alarm=%0d valid=%0d cm=%0d want 1 0 0 20",
               stale, alarm, filtered_valid, filtered_cm);
    end
    drive(1, 0);
    total++;
    if (stale !== 1'b1 || reject_count !== 8'd1) begin
      bad++;
      $display("FAIL timeout_reject_keeps_stale: got stale=%0d rej=%0d want 1 1", stale, reject_count);
    end
    drive(1, 90);
    total++;
    if (stale !== 1'b0 || filtered_valid !== 1'b0 || filtered_strobe !== 1'b0) begin
      bad++;
      $display("FAIL timeout_recover: got stale=%0d valid=%0d strobe=%0d want 0 0 0",
               stale, filtered_valid, filtered_strobe);
    end
    repeat (3) drive(1, 90);
    total++;
    if (filtered_valid !== 1'b1 || filtered_cm !== 8'd90) begin
      bad++;
      $display("FAIL timeout_refill: got valid=%0d cm=%0d want 1 90", filtered_valid, filtered_cm);
    end
  endtask

  task automatic test_timeout_collision();
    apply_reset();
    repeat (4) drive(1, 20);
    repeat (TMO - 2) drive(0, 0);
    drive(1, 24);
    total++;
    if (stale !== 1'b0 || filtered_strobe !== 1'b1 || filtered_valid !== 1'b1 || filtered_cm !== 8'd21) begin
      bad++;
      $display("FAIL collision: got stale=%0d strobe=%0d valid=%0d cm=%0d want 0 1 1 21",
               stale, filtered_strobe, filtered_valid, filtered_cm);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (4) drive(1, 80);
    drive(1, 0);
    drive(1, 10);
    drive(1, 12);
    #5 resetn = 1'b0;
    #1;
    total++;
    if ({filtered_cm, filtered_strobe, filtered_valid, alarm, stale, reject_count} !== 20'd0) begin
      bad++;
      $display("FAIL reset_async: got %h want 0",
               {filtered_cm, filtered_strobe, filtered_valid, alarm, stale, reject_count});
    end
    @(posedge clock);
    #1 resetn = 1'b1;
    m_reset();
    drive(0, 0);
    total++;
    if (filtered_strobe !== 1'b0 || filtered_cm !== 8'd0) begin
      bad++;
      $display("FAIL reset_release: got strobe=%0d cm=%0d want 0 0", filtered_strobe, filtered_cm);
    end
    repeat (4) drive(1, 60);
    total++;
    if (filtered_cm !== 8'd60 || filtered_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_refill: got cm=%0d valid=%0d want 60 1", filtered_cm, filtered_valid);
    end
  endtask

  task automatic test_random();
    int r, v, cm;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 2) != 0) ? 1 : 0;
      if (i > 700 && i < 1720 - TMO) v = 0;
      r = $urandom_range(0, 9);
      if (r == 0) cm = 0;
      else if (r == 1) cm = $urandom_range(201, 255);
      else if (r < 5) cm = $urandom_range(20, 45);
      else cm = $urandom_range(1, 200);
      drive(v, cm);
      total++;
      if (filtered_cm !== 8'(m_cm) || filtered_strobe !== m_strobe[0] ||
          filtered_valid !== m_valid() != 0 || alarm !== m_alarm[0] ||
          stale !== m_stale[0] || reject_count !== 8'(m_rej)) begin
        bad++;
        $display("FAIL random[%0d]: got cm=%0d st=%0d vl=%0d al=%0d sl=%0d rj=%0d want %0d %0d %0d %0d %0d %0d",
                 i, filtered_cm, filtered_strobe, filtered_valid, alarm, stale, reject_count,
                 m_cm, m_strobe, m_valid(), m_alarm, m_stale, m_rej);
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    sample_valid = 1'b0;
    sample_cm = 8'd0;
    m_reset();
    test_reset();
    test_fill();
    test_wrap();
    test_reject();
    test_reject_saturation();
    test_hysteresis();
    test_timeout();
    test_timeout_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
